proj_fm_reader: RTL

- Read-side sequencer for the FM buffer; the write side is filled by the index counter.
- Waits for the writer's end-of-fill pulse, then reads all FM_BUFFER_SIZE entries in address order through the buffer's registered read port.
- Streams the entries downstream over a valid/ready interface, with a 2-entry output FIFO to absorb backpressure.
- Sits between the FM RAM read port and the MinHash consumer.

---
 rtl/proj_fm_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/proj_fm_reader.sv
// FM buffer read sequencer: on a start pulse, reads every buffer entry in
// address order and streams it out through a 2-entry valid/ready FIFO.
//
// Ports:
//   in_clk, in_rst       clock, async active-high reset
//   in_start             buffer-full pulse from the writer
//   out_rd_en/addr       RAM read strobe and address
//   in_rd_data           RAM data, one cycle after out_rd_en
//   out_data/valid/last  output stream (FIFO head), in_ready from consumer
//   out_busy             pass in progress
//   out_overrun          sticky: start seen while busy
package proj_pkg;
  localparam int FM_BUFFER_SIZE = 8;
endpackage

module proj_fm_reader #(
  parameter int DEPTH  = proj_pkg::FM_BUFFER_SIZE,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  output logic              out_rd_en,
  output logic [ADDR_W-1:0] out_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              in_ready,
  output logic              out_last,
  output logic              out_busy,
  output logic              out_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              infl_q;
  logic              infl_last_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic [DATA_W-1:0] head_q, tail_q;
  logic              head_last_q, tail_last_q;
  logic              ovr_q;

  logic       addr_last;
  logic       pop;
  logic       push;
  logic       start_ok;
  logic [2:0] level;

  assign addr_last = (addr_q == ADDR_W'(DEPTH - 1));
  assign pop       = (occ_q != 2'd0) && in_ready;
  assign push      = infl_q;
  assign start_ok  = (state_q == S_IDLE) && in_start;

  // Slots committed after this cycle: stored + returning - leaving.
  // A read is only issued if its data is guaranteed a FIFO slot.
  assign level = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
  assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

  // State register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_start) state_d = S_READ;
      S_READ:  if (out_rd_en && addr_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_rd_en   = (state_q == S_READ) && (level < 3'd2);
    out_rd_addr = addr_q;
    out_busy    = (state_q != S_IDLE);
    out_valid   = (occ_q != 2'd0);
    out_data    = head_q;
    out_last    = head_last_q && out_valid;
    out_overrun = ovr_q;
  end

  // Address counter, in-flight tracking, overrun flag
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (start_ok)
        addr_q <= '0;
      else if (out_rd_en && !addr_last)
        addr_q <= addr_q + 1'b1;
      infl_q      <= out_rd_en;
      infl_last_q <= out_rd_en && addr_last;
      if (in_start && state_q != S_IDLE)
        ovr_q <= 1'b1;
    end
  end

  // Two-register FIFO: head is always the output, so it keeps
  // its last value once the FIFO empties.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      occ_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      head_last_q <= 1'b0;
      tail_last_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      unique case (occ_q)
        2'd0: begin
          if (push) begin
            head_q      <= in_rd_data;
            head_last_q <= infl_last_q;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q      <= in_rd_data;
            head_last_q <= infl_last_q;
          end else if (push) begin
            tail_q      <= in_rd_data;
            tail_last_q <= infl_last_q;
          end
        end
        default: begin
          if (pop) begin
            head_q      <= tail_q;
            head_last_q <= tail_last_q;
            if (push) begin
              tail_q      <= in_rd_data;
              tail_last_q <= infl_last_q;
            end
          end
        end
      endcase
    end
  end

endmodule
